fpu_arbiter: RTL and testbench
==============================

FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default fpu_p::FPU_32, operand/result width passed to the shared fpu_core.
REQ-002 SHALL have parameter TO_CYCLES, default 64, watchdog limit in cycles (used only with FPU_ARB_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 SHALL have ports req_valid[1:0]  input  2  per-requester request valid.
REQ-006 SHALL have ports req_ready[1:0]  output  2  per-requester request accepted this cycle.
REQ-007 SHALL have ports req_op0/req_op1  input  fpu_p::Operation  requested operation.
REQ-008 SHALL have ports req_a0/req_b0/req_a1/req_b1  input  WIDTH  operands.
REQ-009 SHALL have ports rsp_valid[1:0]  output  2  result valid per requester.
REQ-010 SHALL have ports rsp_ready[1:0]  input  2  requester accepts result.
REQ-011 SHALL have port rsp_result  output  WIDTH  result of the granted request.
REQ-012 SHALL have port rsp_err  output  1  result aborted by watchdog (0 when macro absent).
REQ-013 SHALL have ports fpu_start  output  1, fpu_op  output  fpu_p::Operation, fpu_a/fpu_b  output  WIDTH, fpu_busy  input  1, fpu_result  input  WIDTH  -- the fpu_core connection.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-015 IDLE: if any req_valid, grant one requester, assert req_ready for it for exactly one cycle, register op/a/b, go ISSUE.
REQ-016 Arbitration SHALL be round-robin: on simultaneous valid, grant the requester not granted last; after reset requester 0 has priority.
REQ-017 ISSUE: fpu_start=1 for exactly one cycle with registered op/a/b stable; go WAIT.
REQ-018 fpu_op/fpu_a/fpu_b SHALL remain stable from ISSUE until leaving WAIT.
REQ-019 WAIT: ignore fpu_busy in the first WAIT cycle; thereafter on fpu_busy=0 capture fpu_result into rsp_result and go RESP.
REQ-020 RESP: rsp_valid asserted only for the granted requester; rsp_result held stable; on rsp_ready of that requester go IDLE.
REQ-021 req_ready SHALL be 0 outside IDLE; at most one bit of req_ready and rsp_valid high in any cycle.
REQ-022 Minimum latency request-accept to rsp_valid = fpu latency + 3 cycles; back-to-back throughput one op per (fpu latency + 4) cycles with rsp_ready held high.
REQ-023 req_valid deasserted after acceptance SHALL not affect the in-flight operation.
REQ-024 rsp_ready for the non-granted requester SHALL be ignored.

Reset
REQ-025 rst=0 SHALL asynchronously force IDLE, req_ready=0, rsp_valid=0, fpu_start=0, fpu_a/fpu_b=0, rsp_result=0, rsp_err=0, last-grant=1 (so requester 0 wins first).
REQ-026 Reset mid-operation SHALL drop the in-flight request with no response; first cycle after release is IDLE.

Configuration
REQ-027 Macro FPU_ARB_TIMEOUT_EN defined: counter increments each WAIT cycle; reaching TO_CYCLES with fpu_busy still 1 SHALL go RESP with rsp_err=1, rsp_result=0; counter cleared on entering WAIT.
REQ-028 Macro FPU_ARB_TIMEOUT_EN undefined: no counter, WAIT unbounded, rsp_err tied 0, TO_CYCLES unused.

Verification
REQ-029 Single req0 ADD a=0x3F800000 b=0x40000000, rsp_ready=1 -> one fpu_start pulse, rsp_valid[0] with rsp_result=0x40400000, rsp_valid[1]=0.
REQ-030 req0 and req1 valid same cycle after reset -> req0 granted first, req1 granted next; with both kept valid, grants alternate 0,1,0,1.
REQ-031 req1 SUB a=0x40400000 b=0x3F800000, rsp_ready[1]=0 for 5 cycles -> rsp_valid[1] and rsp_result=0x40000000 held 5 cycles, req_ready=0 throughout.
REQ-032 Reset asserted in WAIT -> outputs zero immediately, no rsp_valid after release, next request serviced normally.
REQ-033 With FPU_ARB_TIMEOUT_EN, TO_CYCLES=8, fpu_busy forced 1 -> rsp_valid after 8 WAIT cycles with rsp_err=1, rsp_result=0.
REQ-034 MUL req0 a=0x40000000 b=0x40400000, fpu_busy stimulus checked -> fpu_start exactly one cycle, operands stable until result 0x40C00000 returned.

Source files
------------

// File: rtl/fpu_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_arbiter -- shares a single fpu_core between two requesters.
//
// Accepts one request at a time from two requesters. When both are valid in
// the same cycle, the one that was not granted last wins (round-robin). The
// operation is issued to the fpu_core with a one-cycle fpu_start pulse. The
// result is captured when the core drops fpu_busy. It is then returned to the
// granted requester only.
//
// Optional feature (macro FPU_ARB_TIMEOUT_EN):
//   When defined, a watchdog counts WAIT cycles. If TO_CYCLES is reached while
//   fpu_busy is still high, the arbiter returns rsp_err=1 with rsp_result=0.
//   When undefined, WAIT is unbounded and rsp_err stays 0.
//
// Handshake semantics (all channels): a transfer happens on a rising clk edge
// where both valid and ready are 1. The request side is Mealy: req_ready is
// raised combinationally in IDLE for the single granted requester. The
// response side holds rsp_valid/rsp_result stable until the granted
// requester's rsp_ready.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req_valid/req_ready[1:0] per-requester request handshake
//   req_op0/1, req_a0/1,
//   req_b0/1                 request payloads
//   rsp_valid/rsp_ready[1:0] per-requester response handshake
//   rsp_result, rsp_err      response payload (shared)
//   fpu_start/op/a/b         issue to fpu_core
//   fpu_busy, fpu_result     status/result from fpu_core
//   dbg_state                current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
// -----------------------------------------------------------------------------
package fpu_p;
  localparam int unsigned FPU_32 = 32;
  typedef enum logic [1:0] {
    FPU_ADD = 2'd0,
    FPU_SUB = 2'd1,
    FPU_MUL = 2'd2,
    FPU_DIV = 2'd3
  } Operation;
endpackage

module fpu_arbiter #(
  parameter int unsigned WIDTH     = fpu_p::FPU_32,
  parameter int unsigned TO_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  fpu_p::Operation   req_op0,
  input  fpu_p::Operation   req_op1,
  input  logic [WIDTH-1:0]  req_a0,
  input  logic [WIDTH-1:0]  req_b0,
  input  logic [WIDTH-1:0]  req_a1,
  input  logic [WIDTH-1:0]  req_b1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [WIDTH-1:0]  rsp_result,
  output logic              rsp_err,
  output logic              fpu_start,
  output fpu_p::Operation   fpu_op,
  output logic [WIDTH-1:0]  fpu_a,
  output logic [WIDTH-1:0]  fpu_b,
  input  logic              fpu_busy,
  input  logic [WIDTH-1:0]  fpu_result,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             gnt_q, gnt_d;       // requester owning the in-flight op
  logic             last_q, last_d;     // requester granted most recently
  fpu_p::Operation  op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             start_q, start_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic             first_q, first_d;   // first WAIT cycle: fpu_busy not yet meaningful
  logic             sel;

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TO_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    start_d     = start_q;
    rsp_valid_d = rsp_valid_q;
    result_d    = result_q;
    err_d       = err_q;
    first_d     = first_q;
    req_ready   = 2'b00;
    sel         = 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          // Contention goes to whoever did not win last time.
          sel       = (req_valid == 2'b11) ? ~last_q : req_valid[1];
          req_ready = sel ? 2'b10 : 2'b01;
          gnt_d     = sel;
          last_d    = sel;
          op_d      = sel ? req_op1 : req_op0;
          a_d       = sel ? req_a1  : req_a0;
          b_d       = sel ? req_b1  : req_b0;
          err_d     = 1'b0;
          start_d   = 1'b1;
          state_d   = ISSUE;
        end
      end

      ISSUE: begin
        start_d = 1'b0;
        first_d = 1'b1;
`ifdef FPU_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = WAIT;
      end

      WAIT: begin
        first_d = 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
        cnt_d   = cnt_q + CNT_W'(1);
`endif
        // The core may not have raised busy yet in the first WAIT cycle.
        if (!first_q && !fpu_busy) begin
          result_d    = fpu_result;
          rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
          state_d     = RESP;
        end
`ifdef FPU_ARB_TIMEOUT_EN
        else if (fpu_busy && (32'(cnt_d) >= TO_CYCLES)) begin
          result_d    = '0;
          err_d       = 1'b1;
          rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
          state_d     = RESP;
        end
`endif
      end

      RESP: begin
        // The other requester's rsp_ready is deliberately not looked at.
        if (rsp_ready[gnt_q]) begin
          rsp_valid_d = 2'b00;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;
      op_q        <= fpu_p::FPU_ADD;
      a_q         <= '0;
      b_q         <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= 2'b00;
      result_q    <= '0;
      err_q       <= 1'b0;
      first_q     <= 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      start_q     <= start_d;
      rsp_valid_q <= rsp_valid_d;
      result_q    <= result_d;
      err_q       <= err_d;
      first_q     <= first_d;
`ifdef FPU_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign fpu_start  = start_q;
  assign fpu_op     = op_q;
  assign fpu_a      = a_q;
  assign fpu_b      = b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = result_q;
  assign rsp_err    = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fpu_arbiter -- bench for fpu_arbiter.
//
// Contents:
//   - a behavioural stand-in for fpu_core with a randomly chosen busy time
//   - driver tasks for the two requesters
//   - a monitor holding a transaction-level model of the arbiter, which
//     predicts grants, timing and responses, with a scoreboard queue of
//     expected responses
//   - a final summary report
// -----------------------------------------------------------------------------
module tb_fpu_arbiter;
  localparam int W = 32;
`ifdef FPU_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic            v0, v1;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  fpu_p::Operation req_op0, req_op1;
  logic [W-1:0]    req_a0, req_b0, req_a1, req_b1;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [W-1:0]    rsp_result;
  logic            rsp_err;
  logic            fpu_start;
  fpu_p::Operation fpu_op;
  logic [W-1:0]    fpu_a, fpu_b;
  logic            fpu_busy;
  logic [W-1:0]    fpu_result;
  logic [1:0]      dbg_state;

  assign req_valid = {v1, v0};

  fpu_arbiter #(.WIDTH(W), .TO_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_busy(fpu_busy), .fpu_result(fpu_result),
    .dbg_state(dbg_state)
  );

  // ---------------- reference arithmetic ----------------
  // Exact IEEE results for the named vectors; any other operand pair gets a
  // deterministic scramble, which is enough to see that the right operands
  // went to the core and the right result came back.
  function automatic logic [W-1:0] ref_fpu(input fpu_p::Operation op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    if (op == fpu_p::FPU_ADD && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (op == fpu_p::FPU_SUB && a == 32'h4040_0000 && b == 32'h3F80_0000) return 32'h4000_0000;
    if (op == fpu_p::FPU_MUL && a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    return (a ^ {b[15:0], b[31:16]}) + 32'(op) + 32'd1;
  endfunction

  // ---------------- fpu_core stand-in ----------------
  int next_lat   = 1;   // busy length for the next start, chosen by the model
  bit force_busy = 1'b0;
  int stub_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst)               stub_cnt <= 0;
    else if (fpu_start)     stub_cnt <= next_lat;
    else if (stub_cnt > 0)  stub_cnt <= stub_cnt - 1;
  end
  assign fpu_busy   = force_busy || (stub_cnt != 0);
  assign fpu_result = (stub_cnt != 0) ? 32'hDEAD_BEEF : ref_fpu(fpu_op, fpu_a, fpu_b);

  // ---------------- scoreboard / model state ----------------
  int checks   = 0;
  int failures = 0;

  logic [W+1:0]    exp_q[$];     // {requester, err, result}
  bit              grant_log[$];
  bit              mon_en      = 1'b0;
  bit              outstanding = 1'b0;
  bit              last_g      = 1'b1;
  bit              cur_id      = 1'b0;
  int              acc_cyc     = 0;
  int              rsp_due     = 0;
  fpu_p::Operation op_rec;
  logic [W-1:0]    a_rec, b_rec;
  logic [W-1:0]    last_res;
  int              start_cnt   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [1:0]   exp_rr, exp_rv;
    logic [W+1:0] ent;
    logic [W-1:0] res_e;
    bit           g;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        exp_rr = 2'b00;
        g      = 1'b0;
        if (!outstanding && req_valid != 2'b00) begin
          g      = (req_valid == 2'b11) ? ~last_g : req_valid[1];
          exp_rr = g ? 2'b10 : 2'b01;
        end
        chk("req_ready", 64'(req_ready), 64'(exp_rr));
        chk("fpu_start", 64'(fpu_start), 64'(outstanding && cyc == acc_cyc + 1));
        exp_rv = (outstanding && cyc >= rsp_due) ? (cur_id ? 2'b10 : 2'b01) : 2'b00;
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        if (exp_rv != 2'b00 && exp_q.size() > 0) begin
          chk("rsp_result", 64'(rsp_result), 64'(exp_q[0][W-1:0]));
          chk("rsp_err", 64'(rsp_err), 64'(exp_q[0][W]));
        end
        if (outstanding && cyc > acc_cyc && cyc < rsp_due) begin
          chk("fpu_op_stable", 64'(fpu_op), 64'(op_rec));
          chk("fpu_a_stable", 64'(fpu_a), 64'(a_rec));
          chk("fpu_b_stable", 64'(fpu_b), 64'(b_rec));
        end
        if (fpu_start) start_cnt++;

        if (exp_rv != 2'b00 && rsp_ready[cur_id]) begin
          if (exp_q.size() > 0) begin
            ent      = exp_q.pop_front();
            last_res = rsp_result;
          end
          outstanding = 1'b0;
        end else if (exp_rr != 2'b00) begin
          cur_id   = g;
          last_g   = g;
          grant_log.push_back(g);
          acc_cyc  = cyc;
          op_rec   = g ? req_op1 : req_op0;
          a_rec    = g ? req_a1  : req_a0;
          b_rec    = g ? req_b1  : req_b0;
          next_lat = $urandom_range(1, 5);
          rsp_due  = force_busy ? (acc_cyc + TO + 2) : (acc_cyc + next_lat + 3);
          res_e    = force_busy ? {W{1'b0}} : ref_fpu(op_rec, a_rec, b_rec);
          exp_q.push_back({g, force_busy, res_e});
          outstanding = 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic drive_req(input bit id, input fpu_p::Operation op,
                           input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    bit got = 1'b0;
    if (id) begin req_op1 = op; req_a1 = a; req_b1 = b; v1 = 1'b1; end
    else    begin req_op0 = op; req_a0 = a; req_b0 = b; v0 = 1'b1; end
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1'b1;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL accept_timeout: requester %0d got no req_ready expected grant", id);
    end
    @(posedge clk); #1;
    if (!hold) begin
      if (id) v1 = 1'b0; else v0 = 1'b0;
    end
  endtask

  task automatic rand_driver(input bit id, input int n);
    bit hold_prev = 1'b0;
    bit hold;
    int gap;
    for (int i = 0; i < n; i++) begin
      gap  = hold_prev ? 0 : $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      hold = ($urandom_range(0, 1) == 1) && (i < n - 1);
      drive_req(id, fpu_p::Operation'(2'($urandom_range(0, 3))), $urandom, $urandom, hold);
      hold_prev = hold;
    end
  endtask

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 600 && !ok; k++) begin
      @(negedge clk);
      if (!outstanding && exp_q.size() == 0 && req_valid == 2'b00) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_drain: got %0d pending expected 0", name, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  64'(req_ready),  64'd0);
    chk({tag, "_rsp_valid"},  64'(rsp_valid),  64'd0);
    chk({tag, "_fpu_start"},  64'(fpu_start),  64'd0);
    chk({tag, "_fpu_a"},      64'(fpu_a),      64'd0);
    chk({tag, "_fpu_b"},      64'(fpu_b),      64'd0);
    chk({tag, "_rsp_result"}, 64'(rsp_result), 64'd0);
    chk({tag, "_rsp_err"},    64'(rsp_err),    64'd0);
  endtask

  // ---------------- main sequence ----------------
  bit rand_rr = 1'b0;

  initial begin
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rsp_ready = 2'b11;
    req_op0 = fpu_p::FPU_ADD; req_op1 = fpu_p::FPU_ADD;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    #2 rst = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Both requesters valid after reset and kept valid: 0 first, then alternate.
    grant_log.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) drive_req(1'b0, fpu_p::FPU_ADD, $urandom, $urandom, i < 3);
      end
      begin
        for (int i = 0; i < 4; i++) drive_req(1'b1, fpu_p::FPU_SUB, $urandom, $urandom, i < 3);
      end
    join
    wait_done("alternate");
    chk("alt_grant_count", 64'(grant_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      chk("alt_grant_order", 64'(grant_log[i]), 64'(i % 2));

    // Single ADD on requester 0.
    start_cnt = 0;
    drive_req(1'b0, fpu_p::FPU_ADD, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    wait_done("add");
    chk("add_result", 64'(last_res), 64'h4040_0000);
    chk("add_start_pulses", 64'(start_cnt), 64'd1);

    // SUB on requester 1, response held off for 5 cycles; requester 0's
    // rsp_ready stays high and must be ignored, and a new request must wait.
    rsp_ready = 2'b01;
    drive_req(1'b1, fpu_p::FPU_SUB, 32'h4040_0000, 32'h3F80_0000, 1'b0);
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin
        @(negedge clk);
        if (rsp_valid[1]) seen = 1'b1;
      end
      chk("hold_seen", 64'(seen), 64'd1);
      chk("hold_valid", 64'(rsp_valid), 64'b10);
      chk("hold_result", 64'(rsp_result), 64'h4000_0000);
      @(posedge clk); #1;
      fork
        drive_req(1'b0, fpu_p::FPU_ADD, 32'h0000_0011, 32'h0000_0022, 1'b0);
      join_none
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("hold_valid", 64'(rsp_valid), 64'b10);
        chk("hold_result", 64'(rsp_result), 64'h4000_0000);
        chk("hold_req_ready", 64'(req_ready), 64'd0);
      end
      @(posedge clk); #1;
      rsp_ready = 2'b11;
    end
    wait_done("hold");

    // MUL with operand stability watched by the monitor.
    start_cnt = 0;
    drive_req(1'b0, fpu_p::FPU_MUL, 32'h4000_0000, 32'h4040_0000, 1'b0);
    wait_done("mul");
    chk("mul_result", 64'(last_res), 64'h40C0_0000);
    chk("mul_start_pulses", 64'(start_cnt), 64'd1);

    // Random traffic with random response back-pressure.
    rand_rr = 1'b1;
    fork
      begin
        while (rand_rr) begin
          @(posedge clk); #1;
          rsp_ready = 2'($urandom_range(0, 3));
        end
      end
    join_none
    fork
      rand_driver(1'b0, 12);
      rand_driver(1'b1, 12);
    join
    wait_done("random");
    rand_rr = 1'b0;
    @(posedge clk); #2;
    rsp_ready = 2'b11;
    @(posedge clk); #1;

    // Reset while waiting on the core: everything drops, nothing comes back.
    drive_req(1'b0, fpu_p::FPU_DIV, $urandom, $urandom, 1'b0);
    @(negedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    rst = 1'b0;
    #1 check_reset_outputs("midreset");
    exp_q.delete();
    outstanding = 1'b0;
    last_g      = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    grant_log.delete();
    fork
      drive_req(1'b0, fpu_p::FPU_ADD, $urandom, $urandom, 1'b0);
      drive_req(1'b1, fpu_p::FPU_SUB, $urandom, $urandom, 1'b0);
    join
    wait_done("post_reset");
    chk("post_reset_grants", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() > 0) chk("post_reset_first_grant", 64'(grant_log[0]), 64'd0);

`ifdef FPU_ARB_TIMEOUT_EN
    // Core never finishes: watchdog returns an error response.
    force_busy = 1'b1;
    drive_req(1'b0, fpu_p::FPU_MUL, $urandom, $urandom, 1'b0);
    wait_done("timeout");
    force_busy = 1'b0;
    chk("timeout_result", 64'(last_res), 64'd0);
    @(posedge clk); #1;
`endif

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop if something hangs.
  initial begin
    #500000;
    failures++;
    $display("FAIL global_timeout: got no completion expected finish before 500000ns");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench did not complete");
  end

endmodule
